// File: rtl/hlsm_pkg.sv
// Shared definitions for the sweep generator controller/datapath pair:
// FSM state encoding and the default sample width.
package hlsm_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    UP,
    DOWN,
    DONE
  } state_t;

endpackage

// File: rtl/sweep_datapath.sv
// Sweep datapath: bound/step/current registers, extended-width add/sub with
// clamping to [min, max], and the status flags consumed by the controller.
module sweep_datapath
  import hlsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_capture,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic             i_dec,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_max,
  input  logic [WIDTH-1:0] i_step,
  output logic [WIDTH-1:0] o_cur,
  output logic             cur_eq_max,
  output logic             cur_eq_min,
  output logic             min_gt_max
);

  // Two guard bits: one for sign extension, one because an unsigned step can
  // reach 2^WIDTH-1, so cur+step spans more than WIDTH+1 signed bits.
  localparam int unsigned XW = WIDTH + 2;

  logic signed [WIDTH-1:0] r_cur;
  logic signed [WIDTH-1:0] r_min;
  logic signed [WIDTH-1:0] r_max;
  logic        [WIDTH-1:0] r_step;

  logic        [WIDTH-1:0] w_step_in;
  logic signed [XW-1:0]    w_cur_x;
  logic signed [XW-1:0]    w_min_x;
  logic signed [XW-1:0]    w_max_x;
  logic signed [XW-1:0]    w_step_x;
  logic signed [XW-1:0]    w_sum;
  logic signed [XW-1:0]    w_diff;
  logic signed [WIDTH-1:0] w_up;
  logic signed [WIDTH-1:0] w_dn;

  always_comb begin
    w_step_in = (i_step == '0) ? WIDTH'(1) : i_step;
  end

  always_comb begin
    w_cur_x  = {{2{r_cur[WIDTH-1]}}, r_cur};
    w_min_x  = {{2{r_min[WIDTH-1]}}, r_min};
    w_max_x  = {{2{r_max[WIDTH-1]}}, r_max};
    w_step_x = {2'b00, r_step};
    w_sum    = w_cur_x + w_step_x;
    w_diff   = w_cur_x - w_step_x;
    w_up     = (w_sum > w_max_x)  ? r_max : w_sum[WIDTH-1:0];
    w_dn     = (w_diff < w_min_x) ? r_min : w_diff[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_min  <= '0;
      r_max  <= '0;
      r_step <= '0;
    end else if (i_capture) begin
      r_min  <= i_min;
      r_max  <= i_max;
      r_step <= w_step_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur <= '0;
    end else if (i_load) begin
      r_cur <= r_min;
    end else if (i_inc) begin
      r_cur <= w_up;
    end else if (i_dec) begin
      r_cur <= w_dn;
    end
  end

  always_comb begin
    o_cur      = r_cur;
    cur_eq_max = (r_cur == r_max);
    cur_eq_min = (r_cur == r_min);
    min_gt_max = (r_min > r_max);
  end

endmodule

// File: rtl/sweep_gen.sv
// Triangular sweep generator: emits min..max..min in step increments over a
// valid/ready stream, with an error flag for inverted bounds.
module sweep_gen
  import hlsm_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] min,
  input  logic [WIDTH-1:0] max,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t r_state;
  state_t w_next;
  logic   r_err;

  logic             w_emit;
  logic             w_xfer;
  logic             w_capture;
  logic             w_load;
  logic             w_inc;
  logic             w_dec;
  logic [WIDTH-1:0] w_cur;
  logic             w_cur_eq_max;
  logic             w_cur_eq_min;
  logic             w_min_gt_max;

  sweep_datapath #(
    .WIDTH(WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .i_capture  (w_capture),
    .i_load     (w_load),
    .i_inc      (w_inc),
    .i_dec      (w_dec),
    .i_min      (min),
    .i_max      (max),
    .i_step     (step),
    .o_cur      (w_cur),
    .cur_eq_max (w_cur_eq_max),
    .cur_eq_min (w_cur_eq_min),
    .min_gt_max (w_min_gt_max)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == LOAD) begin
      r_err <= w_min_gt_max;
    end
  end

  always_comb begin
    w_emit = (r_state == UP) || (r_state == DOWN);
    w_xfer = w_emit && out_ready;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_next = LOAD;
      LOAD: w_next = w_min_gt_max ? DONE : UP;
      UP: begin
        if (w_xfer && w_cur_eq_max) begin
          w_next = w_cur_eq_min ? DONE : DOWN;
        end
      end
      DOWN: if (w_xfer && w_cur_eq_min) w_next = DONE;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // At the peak cur==max, so stepping down from cur equals max-step.
  always_comb begin
    w_capture = (r_state == IDLE) && start;
    w_load    = (r_state == LOAD);
    w_inc     = (r_state == UP) && w_xfer && !w_cur_eq_max;
    w_dec     = ((r_state == UP) && w_xfer && w_cur_eq_max && !w_cur_eq_min) ||
                ((r_state == DOWN) && w_xfer && !w_cur_eq_min);
    out       = w_emit ? w_cur : '0;
    out_valid = w_emit;
    busy      = (r_state == LOAD) || w_emit;
    done      = (r_state == DONE);
    err       = r_err;
  end

endmodule

// File: tb/tb_sweep_gen.sv
// Self-checking bench for sweep_gen: directed and random sweeps checked
// against a queue-based reference sweep computed with plain integer math.
module tb_sweep_gen;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] min_i;
  logic [W-1:0] max_i;
  logic [W-1:0] step_i;
  logic [W-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
  logic         done;
  logic         err;

  int checks   = 0;
  int failures = 0;

  longint exp_q[$];

  always #5 clk = ~clk;

  sweep_gen #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .min       (min_i),
    .max       (max_i),
    .step      (step_i),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference sweep: full list of samples from exact integer arithmetic.
  function automatic void model(input longint mn, input longint mx, input longint st);
    longint s;
    longint cur;
    exp_q.delete();
    if (mn > mx) return;
    s   = (st == 0) ? 1 : st;
    cur = mn;
    exp_q.push_back(cur);
    while (cur != mx) begin
      cur = (cur + s > mx) ? mx : cur + s;
      exp_q.push_back(cur);
    end
    if (mn != mx) begin
      while (cur != mn) begin
        cur = (cur - s < mn) ? mn : cur - s;
        exp_q.push_back(cur);
      end
    end
  endfunction

  task automatic run_sweep(input string tag, input logic [W-1:0] mn, input logic [W-1:0] mx,
                           input logic [W-1:0] st, input int ready_pct, input int stall_cycles,
                           input longint stall_val, input int rst_after);
    longint       smn;
    longint       smx;
    longint       e;
    logic [W-1:0] ev;
    logic         exp_err;
    int           xfers;
    int           stall_left;
    bit           stalled_once;
    bit           ended;
    bit           was_reset;
    smn          = longint'($signed(mn));
    smx          = longint'($signed(mx));
    model(smn, smx, longint'(st));
    exp_err      = (smn > smx);
    xfers        = 0;
    stall_left   = 0;
    stalled_once = 0;
    ended        = 0;
    was_reset    = 0;

    @(negedge clk);
    start     = 1'b1;
    min_i     = mn;
    max_i     = mx;
    step_i    = st;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/load_busy"}, 64'(busy), 64'd1);
    chk({tag, "/load_valid"}, 64'(out_valid), 64'd0);

    for (int cyc = 0; cyc < 4000 && !ended; cyc++) begin
      @(negedge clk);
      if (cyc > 0) begin
        min_i  = $urandom;
        max_i  = $urandom;
        step_i = $urandom;
      end
      if (exp_q.size() == 0) begin
        chk({tag, "/done"}, 64'(done), 64'd1);
        chk({tag, "/done_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "/done_busy"}, 64'(busy), 64'd0);
        chk({tag, "/done_err"}, 64'(err), 64'(exp_err));
        ended = 1;
      end else begin
        e  = exp_q[0];
        ev = e[W-1:0];
        chk({tag, "/valid"}, 64'(out_valid), 64'd1);
        chk({tag, "/out"}, 64'(out), 64'(ev));
        chk({tag, "/busy"}, 64'(busy), 64'd1);
        chk({tag, "/nodone"}, 64'(done), 64'd0);
        if (stall_left > 0) begin
          out_ready  = 1'b0;
          stall_left = stall_left - 1;
        end else if (!stalled_once && stall_cycles > 0 && e == stall_val) begin
          stalled_once = 1;
          out_ready    = 1'b0;
          stall_left   = stall_cycles - 1;
        end else begin
          out_ready = ($urandom_range(0, 99) < ready_pct);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          xfers++;
          if (rst_after >= 0 && xfers == rst_after) begin
            @(posedge clk);
            #2 rst = 1'b1;
            #1;
            chk({tag, "/arst_out"}, 64'(out), 64'd0);
            chk({tag, "/arst_valid"}, 64'(out_valid), 64'd0);
            chk({tag, "/arst_busy"}, 64'(busy), 64'd0);
            chk({tag, "/arst_done"}, 64'(done), 64'd0);
            chk({tag, "/arst_err"}, 64'(err), 64'd0);
            @(negedge clk);
            rst = 1'b0;
            for (int k = 0; k < 3; k++) begin
              @(negedge clk);
              chk({tag, "/post_rst_valid"}, 64'(out_valid), 64'd0);
              chk({tag, "/post_rst_busy"}, 64'(busy), 64'd0);
            end
            was_reset = 1;
            ended     = 1;
          end
        end
      end
    end

    if (!ended) begin
      chk({tag, "/timeout"}, 64'd0, 64'd1);
    end else if (!was_reset) begin
      @(negedge clk);
      chk({tag, "/idle_done"}, 64'(done), 64'd0);
      chk({tag, "/idle_busy"}, 64'(busy), 64'd0);
      chk({tag, "/idle_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "/idle_err"}, 64'(err), 64'(exp_err));
    end
  endtask

  initial begin
    logic [W-1:0] rmn;
    logic [W-1:0] rmx;
    logic [W-1:0] rst_step;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    min_i     = '0;
    max_i     = '0;
    step_i    = '0;
    #1;
    chk("reset_out", 64'(out), 64'd0);
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_valid", 64'(out_valid), 64'd0);

    run_sweep("basic",    32'd0, 32'd4, 32'd2, 100, 0, 0, -1);
    run_sweep("clamp",    32'd0, 32'd4, 32'd3, 100, 0, 0, -1);
    run_sweep("single",   32'd5, 32'd5, 32'd1, 100, 0, 0, -1);
    run_sweep("step0",    32'd0, 32'd3, 32'd0, 100, 0, 0, -1);
    run_sweep("bad",      32'd10, 32'd3, 32'd1, 100, 0, 0, -1);
    run_sweep("overflow", 32'h7FFF_FFF0, 32'h7FFF_FFFF, 32'h10, 100, 0, 0, -1);
    run_sweep("underflow", 32'h8000_0000, 32'h8000_000F, 32'hFFFF_FFFF, 100, 0, 0, -1);
    run_sweep("negative", 32'hFFFF_FFFB, 32'd7, 32'd4, 60, 0, 0, -1);
    run_sweep("backpres", 32'd0, 32'd4, 32'd2, 100, 3, 2, -1);
    run_sweep("midreset", 32'd0, 32'd8, 32'd2, 100, 0, 0, 6);
    run_sweep("restart",  32'd0, 32'd4, 32'd2, 100, 0, 0, -1);

    for (int i = 0; i < 30; i++) begin
      if (i % 3 == 0) begin
        rmn      = $urandom;
        rmx      = $urandom;
        rst_step = 32'h4000_0000 | $urandom;
      end else begin
        rmn      = $urandom;
        rmx      = rmn + 32'($urandom_range(0, 200));
        rst_step = 32'($urandom_range(0, 40));
      end
      run_sweep("random", rmn, rmx, rst_step, 50, 0, 0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
